// File: rtl/execute_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_pkg
// Description : Shared ALU op codes, branch-type codes and datapath default.
// Revision    : 1.0 - initial release
// ============================================================================
package execute_stage_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_AND   = 4'd2;
    localparam logic [3:0] c_ALU_OR    = 4'd3;
    localparam logic [3:0] c_ALU_XOR   = 4'd4;
    localparam logic [3:0] c_ALU_SLL   = 4'd5;
    localparam logic [3:0] c_ALU_SRL   = 4'd6;
    localparam logic [3:0] c_ALU_SRA   = 4'd7;
    localparam logic [3:0] c_ALU_SLT   = 4'd8;
    localparam logic [3:0] c_ALU_SLTU  = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6,
        BR_JUMP = 3'd7
    } br_type_e;

endpackage
`default_nettype wire

// File: rtl/execute_stage_alu.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_alu
// Description : Combinational integer ALU used by the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage_alu
    import execute_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result
);

    localparam int c_SHW = $clog2(XLEN);

    logic [c_SHW-1:0] w_shamt;
    assign w_shamt = i_b[c_SHW-1:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            c_ALU_ADD:   o_result = i_a + i_b;
            c_ALU_SUB:   o_result = i_a - i_b;
            c_ALU_AND:   o_result = i_a & i_b;
            c_ALU_OR:    o_result = i_a | i_b;
            c_ALU_XOR:   o_result = i_a ^ i_b;
            c_ALU_SLL:   o_result = i_a << w_shamt;
            c_ALU_SRL:   o_result = i_a >> w_shamt;
            c_ALU_SRA:   o_result = $signed(i_a) >>> w_shamt;
            c_ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            c_ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            c_ALU_PASSB: o_result = i_b;
            default:     o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/execute_stage_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_branch_unit
// Description : Branch/jump resolution: taken decision and redirect target.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage_branch_unit
    import execute_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      i_br_type,
    input  logic            i_is_jalr,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    output logic            o_taken,
    output logic [XLEN-1:0] o_target
);

    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_sum;

    assign w_base   = i_is_jalr ? i_rs1 : i_pc;
    assign w_sum    = w_base + i_imm;
    // Register-based targets are forced halfword aligned.
    assign o_target = i_is_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;

    always_comb begin
        o_taken = 1'b0;
        case (br_type_e'(i_br_type))
            BR_NONE: o_taken = 1'b0;
            BR_BEQ:  o_taken = (i_rs1 == i_rs2);
            BR_BNE:  o_taken = (i_rs1 != i_rs2);
            BR_BLT:  o_taken = ($signed(i_rs1) <  $signed(i_rs2));
            BR_BGE:  o_taken = ($signed(i_rs1) >= $signed(i_rs2));
            BR_BLTU: o_taken = (i_rs1 <  i_rs2);
            BR_BGEU: o_taken = (i_rs1 >= i_rs2);
            BR_JUMP: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : Pipeline EX stage: forwarding, ALU, branch resolution, EX/MEM.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [3:0]      id_alu_op,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [XLEN-1:0] id_rs1_val,
    input  logic [XLEN-1:0] id_rs2_val,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_pc,
    input  logic            id_use_imm,
    input  logic [2:0]      id_br_type,
    input  logic            id_is_jalr,
    input  logic            id_is_load,
    input  logic            id_is_store,
    input  logic [4:0]      id_rd,
    input  logic            id_reg_write,
    input  logic            mem_stall,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_is_load,
    output logic            ex_is_store,
    output logic            ex_redirect,
    output logic [XLEN-1:0] ex_target
);

    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_result;
    logic [XLEN-1:0] r_ex_store_data;
    logic [4:0]      r_ex_rd;
    logic            r_ex_reg_write;
    logic            r_ex_is_load;
    logic            r_ex_is_store;
    logic            r_ex_redirect;
    logic [XLEN-1:0] r_ex_target;

    logic            w_ex_hit_rs1, w_ex_hit_rs2;
    logic            w_wb_hit_rs1, w_wb_hit_rs2;
    logic [XLEN-1:0] w_fwd_rs1, w_fwd_rs2;
    logic [XLEN-1:0] w_op_a, w_op_b;
    logic [XLEN-1:0] w_alu_result;
    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic            w_hazard;
    logic            w_is_jump;

    // Loads are excluded from EX forwarding: their data only exists after MEM.
    assign w_ex_hit_rs1 = FWD_EN && (id_rs1 != 5'd0) && r_ex_valid && r_ex_reg_write
                          && !r_ex_is_load && (r_ex_rd == id_rs1);
    assign w_ex_hit_rs2 = FWD_EN && (id_rs2 != 5'd0) && r_ex_valid && r_ex_reg_write
                          && !r_ex_is_load && (r_ex_rd == id_rs2);
    assign w_wb_hit_rs1 = FWD_EN && (id_rs1 != 5'd0) && wb_valid && wb_reg_write
                          && (wb_rd == id_rs1);
    assign w_wb_hit_rs2 = FWD_EN && (id_rs2 != 5'd0) && wb_valid && wb_reg_write
                          && (wb_rd == id_rs2);

    assign w_fwd_rs1 = w_ex_hit_rs1 ? r_ex_result : (w_wb_hit_rs1 ? wb_data : id_rs1_val);
    assign w_fwd_rs2 = w_ex_hit_rs2 ? r_ex_result : (w_wb_hit_rs2 ? wb_data : id_rs2_val);

    assign w_op_a = id_use_pc  ? id_pc  : w_fwd_rs1;
    assign w_op_b = id_use_imm ? id_imm : w_fwd_rs2;

    assign w_hazard  = id_valid && r_ex_valid && r_ex_is_load && (r_ex_rd != 5'd0)
                       && ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));
    assign w_is_jump = (id_br_type == BR_JUMP);
    assign id_ready  = !rst && !mem_stall && !w_hazard;

    execute_stage_alu #(.XLEN(XLEN)) u_alu (
        .i_op     (id_alu_op),
        .i_a      (w_op_a),
        .i_b      (w_op_b),
        .o_result (w_alu_result)
    );

    execute_stage_branch_unit #(.XLEN(XLEN)) u_branch (
        .i_br_type (id_br_type),
        .i_is_jalr (id_is_jalr),
        .i_rs1     (w_fwd_rs1),
        .i_rs2     (w_fwd_rs2),
        .i_pc      (id_pc),
        .i_imm     (id_imm),
        .o_taken   (w_taken),
        .o_target  (w_target)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid      <= 1'b0;
            r_ex_result     <= '0;
            r_ex_store_data <= '0;
            r_ex_rd         <= 5'd0;
            r_ex_reg_write  <= 1'b0;
            r_ex_is_load    <= 1'b0;
            r_ex_is_store   <= 1'b0;
            r_ex_redirect   <= 1'b0;
            r_ex_target     <= '0;
        end else if (mem_stall) begin
            r_ex_redirect   <= 1'b0;
        end else if (flush || w_hazard || r_ex_redirect) begin
            // Bubble; a pending redirect also squashes the wrong-path instruction.
            r_ex_valid      <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_is_load    <= 1'b0;
            r_ex_is_store   <= 1'b0;
            r_ex_redirect   <= 1'b0;
        end else begin
            r_ex_valid      <= id_valid;
            r_ex_result     <= w_is_jump ? (id_pc + XLEN'(4)) : w_alu_result;
            r_ex_store_data <= w_fwd_rs2;
            r_ex_rd         <= id_rd;
            r_ex_reg_write  <= id_valid && id_reg_write;
            r_ex_is_load    <= id_valid && id_is_load;
            r_ex_is_store   <= id_valid && id_is_store;
            r_ex_redirect   <= id_valid && w_taken;
            r_ex_target     <= w_target;
        end
    end

    assign ex_valid      = r_ex_valid;
    assign ex_result     = r_ex_result;
    assign ex_store_data = r_ex_store_data;
    assign ex_rd         = r_ex_rd;
    assign ex_reg_write  = r_ex_reg_write;
    assign ex_is_load    = r_ex_is_load;
    assign ex_is_store   = r_ex_is_store;
    assign ex_redirect   = r_ex_redirect;
    assign ex_target     = r_ex_target;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage
// Description : Self-checking bench for execute_stage with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [3:0]  id_alu_op;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_pc, id_use_imm, id_is_jalr, id_is_load, id_is_store, id_reg_write;
    logic [2:0]  id_br_type;
    logic        mem_stall, flush, wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid, ex_reg_write, ex_is_load, ex_is_store, ex_redirect;
    logic [31:0] ex_result, ex_store_data, ex_target;
    logic [4:0]  ex_rd;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected architectural contents of the EX/MEM register.
    logic        m_valid, m_rw, m_ld, m_st, m_redir;
    logic [31:0] m_result, m_store, m_target;
    logic [4:0]  m_rd;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_alu_op(id_alu_op), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .id_br_type(id_br_type),
        .id_is_jalr(id_is_jalr), .id_is_load(id_is_load), .id_is_store(id_is_store),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .mem_stall(mem_stall), .flush(flush),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_is_store(ex_is_store), .ex_redirect(ex_redirect), .ex_target(ex_target)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh = int'(b[4:0]);
        case (op)
            c_ALU_ADD:   return a + b;
            c_ALU_SUB:   return a - b;
            c_ALU_AND:   return a & b;
            c_ALU_OR:    return a | b;
            c_ALU_XOR:   return a ^ b;
            c_ALU_SLL:   return a << sh;
            c_ALU_SRL:   return a >> sh;
            c_ALU_SRA:   return 32'($signed(a) >>> sh);
            c_ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            c_ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            c_ALU_PASSB: return b;
            default:     return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] br, input logic [31:0] a, input logic [31:0] b);
        case (br)
            3'd1: return a == b;
            3'd2: return a != b;
            3'd3: return $signed(a) < $signed(b);
            3'd4: return $signed(a) >= $signed(b);
            3'd5: return a < b;
            3'd6: return a >= b;
            3'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return rf;
        if (m_valid && m_rw && !m_ld && m_rd == idx) return m_result;
        if (wb_valid && wb_reg_write && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    function automatic logic ref_hazard();
        return id_valid && m_valid && m_ld && (m_rd != 5'd0) && (m_rd == id_rs1 || m_rd == id_rs2);
    endfunction

    // Advances the model by one edge from the currently driven inputs.
    task automatic tick();
        logic [31:0] f1, f2, a, b;
        logic hz;
        f1 = ref_fwd(id_rs1, id_rs1_val);
        f2 = ref_fwd(id_rs2, id_rs2_val);
        a  = id_use_pc  ? id_pc  : f1;
        b  = id_use_imm ? id_imm : f2;
        hz = ref_hazard();
        @(posedge clk);
        #1;
        if (rst) begin
            {m_valid, m_rw, m_ld, m_st, m_redir} = '0;
            m_result = '0; m_store = '0; m_target = '0; m_rd = '0;
        end else if (mem_stall) begin
            m_redir = 1'b0;
        end else if (flush || hz || m_redir) begin
            {m_valid, m_rw, m_ld, m_st, m_redir} = '0;
        end else begin
            m_valid  = id_valid;
            m_rw     = id_valid && id_reg_write;
            m_ld     = id_valid && id_is_load;
            m_st     = id_valid && id_is_store;
            m_redir  = id_valid && ref_taken(id_br_type, f1, f2);
            m_rd     = id_rd;
            m_store  = f2;
            m_result = (id_br_type == 3'd7) ? id_pc + 32'd4 : ref_alu(id_alu_op, a, b);
            m_target = id_is_jalr ? ((f1 + id_imm) & ~32'd1) : id_pc + id_imm;
        end
    endtask

    task automatic set_nop();
        id_valid = 0; id_alu_op = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0;
        id_rs1_val = 0; id_rs2_val = 0; id_imm = 0; id_use_pc = 0; id_use_imm = 0;
        id_br_type = 0; id_is_jalr = 0; id_is_load = 0; id_is_store = 0; id_rd = 0;
        id_reg_write = 0; mem_stall = 0; flush = 0; wb_valid = 0; wb_reg_write = 0;
        wb_rd = 0; wb_data = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_nop();
        tick(); tick();
        #1;
        n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", id_ready); end
        n_tests++; if ({ex_valid, ex_reg_write, ex_is_load, ex_is_store, ex_redirect} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {ex_valid, ex_reg_write, ex_is_load, ex_is_store, ex_redirect}); end
        n_tests++; if ({ex_result, ex_store_data, ex_target, ex_rd} !== 101'b0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", ex_result, ex_store_data, ex_target, ex_rd); end
        rst = 1'b0;
    endtask

    task automatic test_forward();
        set_nop();
        id_valid = 1; id_alu_op = c_ALU_ADD; id_rs1 = 1; id_rs2 = 2; id_rs1_val = 5; id_rs2_val = 7;
        id_rd = 3; id_reg_write = 1;
        tick();
        n_tests++; if (ex_valid !== 1'b1 || ex_result !== 32'd12) begin
            n_fail++; $display("FAIL fwd_add: got v=%b %0d want v=1 12", ex_valid, ex_result); end
        id_alu_op = c_ALU_SUB; id_rs1 = 3; id_rs1_val = 32'd0; id_rs2 = 1; id_rs2_val = 5; id_rd = 4;
        tick();
        n_tests++; if (ex_result !== 32'd7 || ex_rd !== 5'd4) begin
            n_fail++; $display("FAIL fwd_sub: got %0d rd=%0d want 7 rd=4", ex_result, ex_rd); end
    endtask

    task automatic test_load_use();
        set_nop();
        id_valid = 1; id_alu_op = c_ALU_ADD; id_rs1 = 2; id_rs1_val = 32'h100; id_imm = 8;
        id_use_imm = 1; id_is_load = 1; id_rd = 5; id_reg_write = 1;
        tick();
        n_tests++; if (ex_is_load !== 1'b1 || ex_result !== 32'h108) begin
            n_fail++; $display("FAIL lw_addr: got ld=%b %h want ld=1 00000108", ex_is_load, ex_result); end
        id_is_load = 0; id_rs1 = 5; id_rs1_val = 0; id_imm = 1; id_rd = 6;
        #1;
        n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready: got %b want 0", id_ready); end
        tick();
        n_tests++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_is_load !== 1'b0) begin
            n_fail++; $display("FAIL lu_bubble: got v=%b rw=%b ld=%b want 000", ex_valid, ex_reg_write, ex_is_load); end
        wb_valid = 1; wb_reg_write = 1; wb_rd = 5; wb_data = 32'h40;
        #1;
        n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL lu_ready2: got %b want 1", id_ready); end
        tick();
        n_tests++; if (ex_valid !== 1'b1 || ex_result !== 32'h41) begin
            n_fail++; $display("FAIL lu_wbfwd: got v=%b %h want v=1 00000041", ex_valid, ex_result); end
    endtask

    task automatic test_branch();
        set_nop();
        id_valid = 1; id_br_type = 3'd1; id_rs1 = 1; id_rs2 = 2; id_rs1_val = 9; id_rs2_val = 9;
        id_pc = 32'h100; id_imm = 32'h20;
        tick();
        n_tests++; if (ex_redirect !== 1'b1 || ex_target !== 32'h120) begin
            n_fail++; $display("FAIL beq_taken: got r=%b %h want r=1 00000120", ex_redirect, ex_target); end
        id_br_type = 0; id_alu_op = c_ALU_ADD; id_rd = 7; id_reg_write = 1; id_pc = 32'h104;
        tick();
        n_tests++; if (ex_valid !== 1'b0 || ex_redirect !== 1'b0 || ex_reg_write !== 1'b0) begin
            n_fail++; $display("FAIL beq_squash: got v=%b r=%b rw=%b want 000", ex_valid, ex_redirect, ex_reg_write); end
        id_rs2_val = 8;
        id_br_type = 3'd1; id_reg_write = 0;
        tick();
        n_tests++; if (ex_redirect !== 1'b0 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL beq_not_taken: got r=%b v=%b want r=0 v=1", ex_redirect, ex_valid); end
    endtask

    task automatic test_jump();
        set_nop(); tick();
        id_valid = 1; id_br_type = 3'd7; id_is_jalr = 1; id_rs1 = 1; id_rs1_val = 32'h203;
        id_imm = 0; id_pc = 32'h300; id_rd = 1; id_reg_write = 1;
        tick();
        n_tests++; if (ex_redirect !== 1'b1 || ex_target !== 32'h202 || ex_result !== 32'h304) begin
            n_fail++; $display("FAIL jalr: got r=%b t=%h res=%h want 1 00000202 00000304", ex_redirect, ex_target, ex_result); end
        set_nop(); tick();
        id_valid = 1; id_br_type = 3'd7; id_pc = 32'hFFFF_FFFC; id_imm = 8; id_rd = 1; id_reg_write = 1;
        tick();
        n_tests++; if (ex_result !== 32'h0 || ex_target !== 32'h4) begin
            n_fail++; $display("FAIL jal_wrap: got res=%h t=%h want 00000000 00000004", ex_result, ex_target); end
    endtask

    task automatic test_stall();
        set_nop(); tick();
        id_valid = 1; id_alu_op = c_ALU_ADD; id_rs1 = 1; id_rs2 = 2; id_rs1_val = 1; id_rs2_val = 2;
        id_rd = 8; id_reg_write = 1;
        tick();
        id_rs1_val = 100; id_rd = 9; mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0", i, id_ready); end
            tick();
            n_tests++; if (ex_valid !== 1'b1 || ex_result !== 32'd3 || ex_rd !== 5'd8 || ex_redirect !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b %0d rd=%0d r=%b want 1 3 8 0", i, ex_valid, ex_result, ex_rd, ex_redirect); end
        end
        set_nop(); tick();
        id_valid = 1; id_br_type = 3'd2; id_rs1_val = 1; id_rs2_val = 2; id_pc = 32'h40; id_imm = 32'h10;
        tick();
        mem_stall = 1;
        tick();
        n_tests++; if (ex_redirect !== 1'b0 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL redir_stall: got r=%b v=%b want r=0 v=1", ex_redirect, ex_valid); end
        set_nop(); tick();
        id_valid = 1; id_alu_op = c_ALU_ADD; id_rs1_val = 4; id_rd = 3; id_reg_write = 1;
        tick();
        flush = 1; mem_stall = 1;
        tick();
        n_tests++; if (ex_valid !== 1'b1 || ex_result !== 32'd4) begin
            n_fail++; $display("FAIL flush_stall: got v=%b %0d want v=1 4", ex_valid, ex_result); end
        mem_stall = 0;
        tick();
        n_tests++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
            n_fail++; $display("FAIL flush: got v=%b rw=%b want 00", ex_valid, ex_reg_write); end
    endtask

    task automatic test_reset_mid();
        set_nop(); tick();
        id_valid = 1; id_br_type = 3'd7; id_pc = 32'h80; id_imm = 32'h8; id_rd = 2; id_reg_write = 1;
        tick();
        rst = 1;
        #1;
        n_tests++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 0", id_ready); end
        tick();
        n_tests++; if ({ex_valid, ex_reg_write, ex_is_load, ex_is_store, ex_redirect, ex_rd} !== 10'b0
                       || ex_result !== 32'b0 || ex_target !== 32'b0 || ex_store_data !== 32'b0) begin
            n_fail++; $display("FAIL rst_mid: got v=%b r=%b rd=%0d res=%h t=%h want all 0", ex_valid, ex_redirect, ex_rd, ex_result, ex_target); end
        rst = 0;
    endtask

    task automatic test_random();
        logic exp_ready;
        set_nop(); tick();
        for (int i = 0; i < 400; i++) begin
            id_valid     = ($urandom_range(0, 3) != 0);
            id_alu_op    = 4'($urandom_range(0, 10));
            id_pc        = $urandom & ~32'd3;
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_rs1_val   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4));
            id_rs2_val   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4));
            id_imm       = $urandom;
            id_use_pc    = ($urandom_range(0, 3) == 0);
            id_use_imm   = ($urandom_range(0, 2) == 0);
            id_br_type   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            id_is_jalr   = (id_br_type == 3'd7) && ($urandom_range(0, 1) != 0);
            id_is_load   = ($urandom_range(0, 3) == 0);
            id_is_store  = !id_is_load && ($urandom_range(0, 4) == 0);
            id_rd        = 5'($urandom_range(0, 3));
            id_reg_write = ($urandom_range(0, 3) != 0);
            mem_stall    = ($urandom_range(0, 5) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            wb_valid     = ($urandom_range(0, 1) != 0);
            wb_reg_write = ($urandom_range(0, 3) != 0);
            wb_rd        = 5'($urandom_range(0, 3));
            wb_data      = $urandom;
            #1;
            exp_ready = !mem_stall && !ref_hazard();
            n_tests++; if (id_ready !== exp_ready) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, id_ready, exp_ready); end
            tick();
            n_tests++; if ({ex_valid, ex_reg_write, ex_is_load, ex_is_store, ex_redirect} !== {m_valid, m_rw, m_ld, m_st, m_redir}) begin
                n_fail++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", i,
                    {ex_valid, ex_reg_write, ex_is_load, ex_is_store, ex_redirect}, {m_valid, m_rw, m_ld, m_st, m_redir}); end
            if (m_valid) begin
                n_tests++; if (ex_result !== m_result || ex_store_data !== m_store || ex_rd !== m_rd) begin
                    n_fail++; $display("FAIL rnd_data[%0d]: got %h %h %0d want %h %h %0d", i,
                        ex_result, ex_store_data, ex_rd, m_result, m_store, m_rd); end
            end
            if (m_redir) begin
                n_tests++; if (ex_target !== m_target) begin
                    n_fail++; $display("FAIL rnd_target[%0d]: got %h want %h", i, ex_target, m_target); end
            end
        end
    endtask

    initial begin
        m_valid = 0; m_rw = 0; m_ld = 0; m_st = 0; m_redir = 0;
        m_result = 0; m_store = 0; m_target = 0; m_rd = 0;
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_jump();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline EX stage between the decode stage and the memory stage.
- Selects operands, including forwarding from EX/MEM and WB. Drives the existing combinational ALU and resolves branches and jumps.
- Registers the result into the EX/MEM register with valid/stall/flush control, and raises a one-cycle fetch redirect on taken control transfers.

Parameters:
- XLEN, 32, datapath width.
- FWD_EN, 1, 1 = forwarding paths enabled; 0 = register-file values only (debug).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts the decode instruction this cycle
- id_alu_op  in  4  ALU operation code (shared define constants)
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2  in  5  source register indices
- id_rs1_val, id_rs2_val  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_use_pc  in  1  operand A = PC
- id_use_imm  in  1  operand B = immediate
- id_br_type  in  3  NONE/BEQ/BNE/BLT/BGE/BLTU/BGEU/JUMP
- id_is_jalr  in  1  jump target is register-based
- id_is_load, id_is_store  in  1  memory operation class
- id_rd  in  5  destination register
- id_reg_write  in  1  writes rd
- mem_stall  in  1  memory stage cannot accept
- flush  in  1  kill the instruction being captured (trap/external)
- wb_valid, wb_reg_write  in  1  writeback qualifiers
- wb_rd  in  5  writeback register
- wb_data  in  XLEN  writeback data
- ex_valid  out  1  EX/MEM holds a valid instruction
- ex_result  out  XLEN  ALU result, or PC+4 for jumps
- ex_store_data  out  XLEN  forwarded rs2 value
- ex_rd  out  5  registered destination
- ex_reg_write, ex_is_load, ex_is_store  out  1  registered control
- ex_redirect  out  1  one-cycle taken-branch/jump pulse
- ex_target  out  XLEN  redirect target

Behaviour:
- Reset: every ex_* output = 0; ex_redirect = 0; id_ready = 0 during the reset cycle.
- Latency: 1 cycle. An instruction accepted at edge N appears on ex_* after edge N.
- Forwarding, rs1 and rs2 independently (when FWD_EN = 1):
  - Index 0 always takes the register-file value.
  - Else if ex_valid & ex_reg_write & !ex_is_load & ex_rd == index: take ex_result (highest priority).
  - Else if wb_valid & wb_reg_write & wb_rd == index: take wb_data.
  - Else take the register-file value.
- Load-use hazard: asserted when id_valid & ex_valid & ex_is_load & ex_rd != 0 & ex_rd matches rs1 or rs2. The hazard is conservative: it triggers regardless of whether the instruction actually uses that source.
- Operands: A = id_use_pc ? id_pc : fwd_rs1. B = id_use_imm ? id_imm : fwd_rs2.
- Branch compare:
  - Uses fwd_rs1/fwd_rs2; BLT/BGE are signed, BLTU/BGEU unsigned.
  - JUMP is always taken.
  - Target: jalr gives (fwd_rs1 + id_imm) & ~1; otherwise id_pc + id_imm.
  - Jumps write id_pc + 4 to ex_result.
- id_ready = !rst & !mem_stall & !hazard.
- Update priority per edge:
  1. rst
  2. mem_stall: hold all ex_* registers; ex_redirect forced 0.
  3. flush or hazard or ex_redirect: ex_valid <= 0 (bubble); ex_redirect <= 0. The ex_redirect case squashes the wrong-path instruction behind a taken transfer.
  4. Otherwise capture: ex_valid <= id_valid; ex_redirect <= id_valid & taken.
- A bubble's ex_reg_write, ex_is_load and ex_is_store are cleared.
- ex_redirect is high for exactly one cycle, even if mem_stall rises the following cycle.
- flush together with mem_stall: the stall wins (the held instruction is older). The flush source must stay asserted until the stall releases.
- Arithmetic wraps modulo 2^XLEN; PC+4 overflow wraps.

Decomposition:
- Shared define file: ALU op codes, branch-type codes (BR_NONE = 0 … BR_JUMP = 7), XLEN default.
- Sub-modules:
  - The existing combinational ALU, instantiated as-is.
  - One natural new sub-module, branch_unit: compare plus target, purely combinational.

Test Plan:
- ADD x3,x1,x2 with rs1_val = 5, rs2_val = 7, then SUB x4,x3,x1 on the next cycle -> ex_result 12, then 7 (EX forward of 12).
- LW x5 followed by ADDI x6,x5,1 -> id_ready = 0 for one cycle, one bubble with ex_valid = 0, then ADDI uses wb_data.
- BEQ with equal operands, pc = 0x100, imm = 0x20 -> ex_redirect one cycle, ex_target = 0x120. The next decode instruction is squashed (ex_valid = 0).
- JALR with rs1 = 0x203, imm = 0 -> target 0x202, ex_result = pc + 4.
- mem_stall held for 3 cycles with a valid instruction in EX -> ex_* unchanged, id_ready = 0, no redirect.
- rst asserted mid-stream with valid instructions and a pending redirect -> next cycle all ex_* = 0.
